// File: rtl/pipe_pkg.sv
// Types shared by the execute/memory pipeline stages: the EX->MEM payload,
// the skid-buffer occupancy encoding, and the hard-wired zero register.
package pipe_pkg;

    localparam int PIPE_DW  = 32;
    localparam int PIPE_AW  = 5;
    localparam int PIPE_PCW = 32;

    localparam logic [PIPE_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [PIPE_PCW-1:0] pc;
        logic [PIPE_DW-1:0]  alu_data;
        logic [PIPE_DW-1:0]  st_data;
        logic [PIPE_AW-1:0]  rd_addr;
        logic                rd_wren;
        logic                mem_rden;
        logic                mem_wren;
        logic [2:0]          funct3;
    } ex_mem_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/ex_mem_skid.sv
// EX->MEM stage with a two-entry skid buffer, registered ready and youngest-result forwarding.
// Optional macro EX_MEM_PERF_CNT_EN adds saturating stall/bubble counters.
module ex_mem_skid
    import pipe_pkg::*;
#(
    parameter int DW  = PIPE_DW,
    parameter int AW  = PIPE_AW,
    parameter int PCW = PIPE_PCW
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_flush,
    input  logic           i_ex_valid,
    output logic           o_ex_ready,
    input  logic [PCW-1:0] i_ex_pc,
    input  logic [DW-1:0]  i_ex_alu_data,
    input  logic [DW-1:0]  i_ex_st_data,
    input  logic [AW-1:0]  i_ex_rd_addr,
    input  logic           i_ex_rd_wren,
    input  logic           i_ex_mem_rden,
    input  logic           i_ex_mem_wren,
    input  logic [2:0]     i_ex_funct3,
    output logic           o_mem_valid,
    input  logic           i_mem_ready,
    output logic [PCW-1:0] o_mem_pc,
    output logic [DW-1:0]  o_mem_alu_data,
    output logic [DW-1:0]  o_mem_st_data,
    output logic [AW-1:0]  o_mem_rd_addr,
    output logic           o_mem_rd_wren,
    output logic           o_mem_mem_rden,
    output logic           o_mem_mem_wren,
    output logic [2:0]     o_mem_funct3,
    output logic           o_fwd_valid,
    output logic [AW-1:0]  o_fwd_rd_addr,
    output logic [DW-1:0]  o_fwd_data,
    output logic           o_fwd_is_load
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [31:0]    o_stall_cnt,
    output logic [31:0]    o_bubble_cnt
`endif
);

    occ_t    occ_reg, occ_next;
    ex_mem_t head_reg, head_next;
    ex_mem_t tail_reg, tail_next;
    ex_mem_t in_entry;
    ex_mem_t youngest;
    logic    ex_ready_reg;
    logic    accept;
    logic    pop;
    logic    has_entry;

    assign in_entry = '{
        pc:       i_ex_pc,
        alu_data: i_ex_alu_data,
        st_data:  i_ex_st_data,
        rd_addr:  i_ex_rd_addr,
        rd_wren:  i_ex_rd_wren,
        mem_rden: i_ex_mem_rden,
        mem_wren: i_ex_mem_wren,
        funct3:   i_ex_funct3
    };

    assign has_entry = (occ_reg != EMPTY);
    assign accept    = i_ex_valid & ex_ready_reg;
    assign pop       = has_entry & i_mem_ready;

    // Flush only drops occupancy; stale payload is left in place and is masked by o_mem_valid.
    always_comb begin
        occ_next  = occ_reg;
        head_next = head_reg;
        tail_next = tail_reg;
        if (i_flush) begin
            occ_next = EMPTY;
        end else begin
            case (occ_reg)
                EMPTY: begin
                    if (accept) begin
                        occ_next  = ONE;
                        head_next = in_entry;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        occ_next  = TWO;
                        tail_next = in_entry;
                    end else if (accept && pop) begin
                        head_next = in_entry;
                    end else if (pop) begin
                        occ_next = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        occ_next  = ONE;
                        head_next = tail_reg;
                    end
                end
                default: occ_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            occ_reg      <= EMPTY;
            head_reg     <= '0;
            tail_reg     <= '0;
            ex_ready_reg <= 1'b1;
        end else begin
            occ_reg      <= occ_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            ex_ready_reg <= (occ_next != TWO);
        end
    end

    assign o_ex_ready     = ex_ready_reg;
    assign o_mem_valid    = has_entry;
    assign o_mem_pc       = head_reg.pc;
    assign o_mem_alu_data = head_reg.alu_data;
    assign o_mem_st_data  = head_reg.st_data;
    assign o_mem_rd_addr  = head_reg.rd_addr;
    assign o_mem_rd_wren  = head_reg.rd_wren;
    assign o_mem_mem_rden = head_reg.mem_rden;
    assign o_mem_mem_wren = head_reg.mem_wren;
    assign o_mem_funct3   = head_reg.funct3;

    // The youngest in-flight result is what execute would otherwise read stale from the RF.
    assign youngest      = (occ_reg == TWO) ? tail_reg : head_reg;
    assign o_fwd_valid   = has_entry & youngest.rd_wren & (youngest.rd_addr != REG_ZERO);
    assign o_fwd_rd_addr = has_entry ? youngest.rd_addr : '0;
    assign o_fwd_data    = has_entry ? youngest.alu_data : '0;
    assign o_fwd_is_load = o_fwd_valid & youngest.mem_rden;

`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] bubble_cnt_reg;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (i_ex_valid && !ex_ready_reg && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (!has_entry && (bubble_cnt_reg != '1)) begin
                bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
            end
        end
    end

    assign o_stall_cnt  = stall_cnt_reg;
    assign o_bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- Execute-to-memory pipeline stage with a two-entry skid buffer. It sits directly downstream of the ALU/shifter result mux in the pipelined core.
- Captures one execute-stage result per cycle (ALU/shift result, store data, destination register, memory controls) and presents it to the memory stage with a valid/ready handshake.
- Absorbs one cycle of memory-stage backpressure without a combinational ready path back into execute.
- Also drives forwarding information for the youngest in-flight result back to the execute stage.

Parameters:
- DW, 32, data width of ALU result and store data.
- AW, 5, register-file address width.
- PCW, 32, PC width.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous kill of all buffered entries (trap/redirect).
- i_ex_valid  in  1  execute stage presents a result.
- o_ex_ready  out  1  stage can accept; registered, equals "not full".
- i_ex_pc  in  PCW  instruction PC.
- i_ex_alu_data  in  DW  ALU/shifter result, or effective address for load/store.
- i_ex_st_data  in  DW  store data (rs2).
- i_ex_rd_addr  in  AW  destination register.
- i_ex_rd_wren  in  1  writes register file.
- i_ex_mem_rden  in  1  load.
- i_ex_mem_wren  in  1  store.
- i_ex_funct3  in  3  access size/sign.
- o_mem_valid  out  1  head entry valid.
- i_mem_ready  in  1  memory stage consumes head.
- o_mem_pc, o_mem_alu_data, o_mem_st_data, o_mem_rd_addr, o_mem_rd_wren, o_mem_mem_rden, o_mem_mem_wren, o_mem_funct3  out  as inputs  head entry payload.
- o_fwd_valid  out  1  youngest entry writes a nonzero rd.
- o_fwd_rd_addr  out  AW  its rd.
- o_fwd_data  out  DW  its alu_data.
- o_fwd_is_load  out  1  youngest entry is a load; execute must stall, not forward.

Behaviour:
- Handshake:
  - accept = i_ex_valid & o_ex_ready.
  - pop = o_mem_valid & i_mem_ready.
  - Inputs are sampled only on accept. Payload is held stable while o_mem_valid=1 and i_mem_ready=0.
- Occupancy state machine, 2-bit count:
  - EMPTY (0):
    - accept -> ONE, with the new entry at head.
  - ONE (1):
    - accept & !pop -> TWO, new entry to tail.
    - pop & !accept -> EMPTY.
    - accept & pop -> ONE, new entry replaces head.
  - TWO (2):
    - o_ex_ready=0, so accept is impossible.
    - pop -> ONE, tail moves to head.
- o_ex_ready is a flop, 1 unless the next state is TWO. There is no combinational path from i_mem_ready to o_ex_ready.
- Latency: accept in cycle N -> o_mem_valid with that payload in cycle N+1 when the buffer was EMPTY, or when it was ONE with a simultaneous pop.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- Flush: i_flush=1 -> next state EMPTY and o_mem_valid=0. Flush overrides accept and pop in the same cycle; an entry accepted that cycle is dropped. o_ex_ready is 1 the cycle after a flush.
- Reset (i_reset=0, asynchronous):
  - count=0, o_mem_valid=0, o_ex_ready=1.
  - All payload registers 0, all fwd outputs 0.
  - A reset mid-transfer discards everything.
- Forwarding, combinational from registered state:
  - Youngest entry is tail when TWO, head when ONE; when EMPTY, all o_fwd_* are 0.
  - o_fwd_valid = youngest.rd_wren & (youngest.rd_addr != 0).
  - o_fwd_is_load = youngest.mem_rden & o_fwd_valid.
- Rd_addr 0 never asserts o_fwd_valid.
- Payload of invalid slots retains its old value and is not observable at o_mem_* except o_mem_valid=0.

Optional Feature:
- Macro EX_MEM_PERF_CNT_EN.
- When defined:
  - Adds outputs o_stall_cnt[31:0], counting cycles with i_ex_valid=1 & o_ex_ready=0.
  - Adds o_bubble_cnt[31:0], counting cycles with o_mem_valid=0.
  - Both counters reset to 0 on i_reset, saturate at all-ones, and are not cleared by i_flush.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - ex_mem_t packed struct (pc, alu_data, st_data, rd_addr, rd_wren, mem_rden, mem_wren, funct3).
  - Occupancy enum {EMPTY, ONE, TWO}.
  - Constant REG_ZERO = 0.
- No sub-module. Head and tail are two ex_mem_t registers inside one module.

Test Plan:
- Reset check: assert i_reset=0 mid-stream with two entries held -> o_mem_valid=0, o_ex_ready=1, o_fwd_valid=0 immediately; after release, the first accepted entry appears one cycle later.
- Full-rate streaming: i_mem_ready=1, accept PC 0x00,0x04,0x08 on consecutive cycles -> o_mem_pc shows 0x00,0x04,0x08 in cycles N+1..N+3; o_ex_ready stays 1.
- Backpressure: i_mem_ready=0, accept alu_data 0xAAAA then 0x5555 -> o_ex_ready=0 after the second; head stays 0xAAAA. Raise ready -> 0xAAAA then 0x5555 drain in order; o_ex_ready=1 one cycle after the first pop.
- Flush with accept: state TWO, pop and i_flush in the same cycle as a new offer -> next cycle o_mem_valid=0, nothing delivered, o_ex_ready=1.
- Forwarding: TWO with head rd=5 (ALU) and tail rd=5 (load, alu_data 0x100) -> o_fwd_valid=1, o_fwd_data=0x100, o_fwd_is_load=1. An entry with rd=0 and rd_wren=1 -> o_fwd_valid=0.
- Perf counters (EX_MEM_PERF_CNT_EN): hold i_ex_valid=1 while full for 3 cycles -> o_stall_cnt=3; a later flush leaves it 3.
